keypad_set_controller: RTL and testbench
========================================

Name: keypad_set_controller

Overview:
Sequences keypad entry of a new time or alarm value for the alarm clock.
- A mode button press starts an entry session.
- Four one-hot keypad presses are collected as BCD digits in HH:MM order, then range-checked.
- A valid value produces a single-cycle load strobe to the timekeeping or alarm register; an invalid value produces an error pulse.
- Sits between the raw user inputs (alarm_button, time_button, keypad_buttons) and the clock/alarm datapath registers.

Parameters:
TIMEOUT_CYCLES, 24'd10_000_000, idle cycles allowed between keys before the entry aborts (used only with the optional feature).
TIMEOUT_W, 24, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
alarm_button  input  1  level, pre-debounced; a rising edge starts alarm entry
time_button  input  1  level, pre-debounced; a rising edge starts time entry
keypad_buttons  input  10  level, bit n = digit n pressed
entry_active  output  1  high while collecting digits
entry_mode  output  1  0 = time entry, 1 = alarm entry
digit_count  output  3  digits captured so far, 0..4
entry_digits  output  16  {H tens, H units, M tens, M units} BCD, for display echo
load_time  output  1  one-cycle strobe: load load_value into the time register
load_alarm  output  1  one-cycle strobe: load load_value into the alarm register
load_value  output  16  BCD HHMM, valid while a load strobe is high
entry_error  output  1  one-cycle pulse on invalid value or timeout abort

Behaviour:
- Reset (async, reset=0): state IDLE; every output 0; input history registers 0.
- Edge detection: alarm_button, time_button and key_any (OR of keypad_buttons) are each registered once. Edge = current & ~registered. One cycle of latency from input rise to action.
- Key validity: a key edge counts only if keypad_buttons is exactly one-hot on that cycle. A non-one-hot edge is ignored, with no error. The key is encoded to a 4-bit digit 0..9.
- FSM states: IDLE, ENTER, CHECK, LOAD.
- IDLE:
  - time edge → ENTER with entry_mode=0.
  - alarm edge → ENTER with entry_mode=1.
  - Both edges on the same cycle → time wins.
  - Entering ENTER clears digit_count and entry_digits. Key edges in IDLE are ignored.
- ENTER:
  - Valid key edge: shift the digit into entry_digits from the LSB end (previous digits move up 4 bits). Increment digit_count.
  - When digit_count reaches 4 → CHECK on the next clock.
  - Mode edge in ENTER: restart in the new mode, clearing digits; same-cycle priority as IDLE.
  - Mode edge and key edge on the same cycle: the mode edge wins and the key is discarded.
- CHECK (1 cycle): the value is valid iff all four conditions hold:
  - H tens ≤ 2
  - if H tens = 2, H units ≤ 3
  - M tens ≤ 5
  - every digit ≤ 9
  Valid → LOAD. Invalid → pulse entry_error, go to IDLE.
- LOAD (1 cycle):
  - Drive load_value = entry_digits.
  - Pulse load_time (mode 0) or load_alarm (mode 1); never both.
  - Next state IDLE.
- entry_active = 1 in ENTER and CHECK only.
- Outputs are registered; load_value holds its last value in IDLE.
- Reset asserted mid-entry: the entry is discarded immediately; no strobe is issued.
- Buttons held high: no repeat action. A new action needs a release then a press.

Optional Feature:
KEYPAD_TIMEOUT_EN.
- Defined: in ENTER, a counter increments every cycle and clears on each valid key edge or restart. When it reaches TIMEOUT_CYCLES-1, pulse entry_error, go to IDLE and discard the digits.
- Undefined: no counter is instantiated; ENTER waits indefinitely.

Decomposition:
- Shared package alarmclock_pkg holds:
  - FSM state enum: IDLE, ENTER, CHECK, LOAD.
  - Mode constants: MODE_TIME=1'b0, MODE_ALARM=1'b1.
  - BCD limits: 2, 3, 5, 9.
  - Digit-count constant NUM_DIGITS=4.
- One sub-module: keypad_encoder. It is combinational: 10-bit one-hot input to 4-bit digit plus a valid flag (exactly one bit set).

Test Plan:
- Time entry: time_button edge, then keys 1,2,3,4 → one cycle after CHECK, load_time=1 for exactly one cycle, load_value=16'h1234, load_alarm=0.
- Alarm entry: alarm_button edge, keys 0,6,3,0 → load_alarm pulse with load_value=16'h0630; entry_mode=1 throughout entry.
- Invalid value: time entry of 2,4,0,0 → entry_error single pulse, no load strobe, return to IDLE; 2,3,5,9 → load_time with 16'h2359.
- Non-one-hot and repeat: keypad_buttons=10'b0000000011 mid-entry → digit_count unchanged; a key held for 50 cycles → exactly one digit captured.
- Restart and priority:
  - Alarm edge after 2 time digits → digit_count=0, entry_mode=1.
  - Simultaneous alarm+time edges in IDLE → entry_mode=0.
  - reset pulled low after 3 digits → all outputs 0 asynchronously, no strobe after release.
- Timeout (KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=16): time edge, key 1, then 16 idle cycles → entry_error pulse, entry_active=0, digits cleared.

Source files
------------

// File: rtl/alarmclock_pkg.sv
// Shared types and constants for the alarm clock keypad entry path.
package alarmclock_pkg;

  localparam int unsigned NUM_KEYS   = 10;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned COUNT_W    = 3;
  localparam int unsigned HHMM_W     = NUM_DIGITS * DIGIT_W;

  localparam logic MODE_TIME  = 1'b0;
  localparam logic MODE_ALARM = 1'b1;

  // BCD range limits for a 24-hour HH:MM value
  localparam logic [DIGIT_W-1:0] BCD_HT_MAX    = 4'd2;
  localparam logic [DIGIT_W-1:0] BCD_HU_MAX_20 = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_MT_MAX    = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    CHECK = 2'd2,
    LOAD  = 2'd3
  } entry_state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] h_tens;
    logic [DIGIT_W-1:0] h_units;
    logic [DIGIT_W-1:0] m_tens;
    logic [DIGIT_W-1:0] m_units;
  } hhmm_t;

  // True when the BCD HH:MM value is a legal 24-hour time
  function automatic logic hhmm_valid(input hhmm_t v);
    logic ok;
    ok = (v.h_tens  <= BCD_HT_MAX)    &&
         (v.m_tens  <= BCD_MT_MAX)    &&
         (v.h_units <= BCD_DIGIT_MAX) &&
         (v.m_units <= BCD_DIGIT_MAX);
    if ((v.h_tens == BCD_HT_MAX) && (v.h_units > BCD_HU_MAX_20)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/keypad_encoder.sv
// Combinational one-hot keypad to BCD digit encoder; valid only for exactly one key.
module keypad_encoder
  import alarmclock_pkg::*;
(
  input  logic [NUM_KEYS-1:0] i_keys,
  output logic [DIGIT_W-1:0]  o_digit_c,
  output logic                o_valid_c
);

  // Encode the set bit index and flag the exactly-one-hot case
  always_comb begin
    o_digit_c = '0;
    for (int unsigned n = 0; n < NUM_KEYS; n++) begin
      if (i_keys[n]) begin
        o_digit_c = DIGIT_W'(n);
      end
    end
    o_valid_c = (i_keys != '0) && ((i_keys & (i_keys - NUM_KEYS'(1))) == '0);
  end

endmodule

// File: rtl/keypad_set_controller.sv
// Keypad entry sequencer for new time/alarm values: collects four BCD digits,
// range-checks them and issues a one-cycle load strobe or an error pulse.
// Optional inter-key timeout abort is enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_set_controller
  import alarmclock_pkg::*;
#(
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(10_000_000)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alarm_button,
  input  logic                time_button,
  input  logic [NUM_KEYS-1:0] keypad_buttons,
  output logic                entry_active,
  output logic                entry_mode,
  output logic [COUNT_W-1:0]  digit_count,
  output logic [HHMM_W-1:0]   entry_digits,
  output logic                load_time,
  output logic                load_alarm,
  output logic [HHMM_W-1:0]   load_value,
  output logic                entry_error
);

  entry_state_t        r_state, w_state_d;
  logic                r_alarm_q, r_time_q, r_key_q;
  logic                r_mode, w_mode_d;
  logic [COUNT_W-1:0]  r_count, w_count_d;
  hhmm_t               r_digits, w_digits_d;
  logic                r_active, w_active_d;
  logic                r_load_time, w_load_time_d;
  logic                r_load_alarm, w_load_alarm_d;
  logic [HHMM_W-1:0]   r_load_value, w_load_value_d;
  logic                r_error, w_error_d;

  logic                w_alarm_edge, w_time_edge, w_key_edge, w_key_valid;
  logic                w_mode_edge;
  logic [DIGIT_W-1:0]  w_key_digit_c;
  logic                w_onehot_c;
  logic                w_timer_clr;
  logic                w_timeout;

  keypad_encoder u_encoder (
    .i_keys    (keypad_buttons),
    .o_digit_c (w_key_digit_c),
    .o_valid_c (w_onehot_c)
  );

  assign w_alarm_edge = alarm_button & ~r_alarm_q;
  assign w_time_edge  = time_button & ~r_time_q;
  assign w_key_edge   = (|keypad_buttons) & ~r_key_q;
  assign w_key_valid  = w_key_edge & w_onehot_c;
  assign w_mode_edge  = w_alarm_edge | w_time_edge;

`ifdef KEYPAD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_idle_cnt;

  // Idle-cycle counter for the inter-key timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (w_timer_clr) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TIMEOUT_W'(1);
    end
  end

  assign w_timeout = (r_idle_cnt == (TIMEOUT_CYCLES - TIMEOUT_W'(1)));
`else
  logic w_unused_timeout_cfg;

  // Timeout compiled out: keep its configuration referenced, never fire
  assign w_timeout            = 1'b0;
  assign w_unused_timeout_cfg = ^{TIMEOUT_CYCLES, w_timer_clr};
`endif

  // State, input history and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_alarm_q    <= 1'b0;
      r_time_q     <= 1'b0;
      r_key_q      <= 1'b0;
      r_mode       <= MODE_TIME;
      r_count      <= '0;
      r_digits     <= '0;
      r_active     <= 1'b0;
      r_load_time  <= 1'b0;
      r_load_alarm <= 1'b0;
      r_load_value <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_alarm_q    <= alarm_button;
      r_time_q     <= time_button;
      r_key_q      <= |keypad_buttons;
      r_mode       <= w_mode_d;
      r_count      <= w_count_d;
      r_digits     <= w_digits_d;
      r_active     <= w_active_d;
      r_load_time  <= w_load_time_d;
      r_load_alarm <= w_load_alarm_d;
      r_load_value <= w_load_value_d;
      r_error      <= w_error_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_d      = r_state;
    w_mode_d       = r_mode;
    w_count_d      = r_count;
    w_digits_d     = r_digits;
    w_load_time_d  = 1'b0;
    w_load_alarm_d = 1'b0;
    w_load_value_d = r_load_value;
    w_error_d      = 1'b0;
    w_timer_clr    = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_mode_edge) begin
          w_state_d  = ENTER;
          w_mode_d   = w_time_edge ? MODE_TIME : MODE_ALARM;
          w_count_d  = '0;
          w_digits_d = '0;
        end
      end
      ENTER: begin
        w_timer_clr = 1'b0;
        if (w_mode_edge) begin
          // Restart wins over any key on the same cycle
          w_mode_d    = w_time_edge ? MODE_TIME : MODE_ALARM;
          w_count_d   = '0;
          w_digits_d  = '0;
          w_timer_clr = 1'b1;
        end else if (w_key_valid) begin
          w_digits_d  = {r_digits.h_units, r_digits.m_tens, r_digits.m_units, w_key_digit_c};
          w_count_d   = r_count + COUNT_W'(1);
          w_timer_clr = 1'b1;
          if (r_count == COUNT_W'(NUM_DIGITS - 1)) begin
            w_state_d = CHECK;
          end
        end else if (w_timeout) begin
          w_state_d  = IDLE;
          w_error_d  = 1'b1;
          w_count_d  = '0;
          w_digits_d = '0;
        end
      end
      CHECK: begin
        if (hhmm_valid(r_digits)) begin
          w_state_d      = LOAD;
          w_load_value_d = r_digits;
          w_load_time_d  = (r_mode == MODE_TIME);
          w_load_alarm_d = (r_mode == MODE_ALARM);
        end else begin
          w_state_d = IDLE;
          w_error_d = 1'b1;
        end
      end
      LOAD: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase

    w_active_d = (w_state_d == ENTER) || (w_state_d == CHECK);
  end

  assign entry_active = r_active;
  assign entry_mode   = r_mode;
  assign digit_count  = r_count;
  assign entry_digits = r_digits;
  assign load_time    = r_load_time;
  assign load_alarm   = r_load_alarm;
  assign load_value   = r_load_value;
  assign entry_error  = r_error;

endmodule

// File: tb/tb_keypad_set_controller.sv
// Self-checking bench for keypad_set_controller (KEYPAD_TIMEOUT_EN adds the timeout case).
module tb_keypad_set_controller;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int HOLD_CYCLES = 10;
`else
  localparam int HOLD_CYCLES = 50;
`endif
  localparam int NUM_VECS = 35;

  logic        clk = 1'b0;
  logic        reset;
  logic        alarm_button;
  logic        time_button;
  logic [9:0]  keypad_buttons;
  logic        entry_active;
  logic        entry_mode;
  logic [2:0]  digit_count;
  logic [15:0] entry_digits;
  logic        load_time;
  logic        load_alarm;
  logic [15:0] load_value;
  logic        entry_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  keypad_set_controller #(
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .alarm_button   (alarm_button),
    .time_button    (time_button),
    .keypad_buttons (keypad_buttons),
    .entry_active   (entry_active),
    .entry_mode     (entry_mode),
    .digit_count    (digit_count),
    .entry_digits   (entry_digits),
    .load_time      (load_time),
    .load_alarm     (load_alarm),
    .load_value     (load_value),
    .entry_error    (entry_error)
  );

  typedef struct {
    logic        tb;
    logic        ab;
    logic [9:0]  keys;
    logic        act;
    logic        mode;
    logic [2:0]  cnt;
    logic [15:0] dig;
    logic        lt;
    logic        la;
    logic [15:0] lv;
    logic        err;
  } vec_t;

  vec_t vecs [NUM_VECS];

  function automatic vec_t mk(input logic tb, input logic ab, input logic [9:0] keys,
                              input logic act, input logic mode, input logic [2:0] cnt,
                              input logic [15:0] dig, input logic lt, input logic la,
                              input logic [15:0] lv, input logic err);
    vec_t v;
    v.tb = tb; v.ab = ab; v.keys = keys; v.act = act; v.mode = mode; v.cnt = cnt;
    v.dig = dig; v.lt = lt; v.la = la; v.lv = lv; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic tb, input logic ab, input logic [9:0] keys);
    time_button    = tb;
    alarm_button   = ab;
    keypad_buttons = keys;
    @(negedge clk);
  endtask

  task automatic press(input int d);
    logic [9:0] k;
    k    = '0;
    k[d] = 1'b1;
    step(1'b0, 1'b0, k);
    step(1'b0, 1'b0, 10'h000);
  endtask

  task automatic wait_event(output logic seen, output logic lt, output logic la,
                            output logic er, output logic [15:0] lv);
    seen = 1'b0; lt = 1'b0; la = 1'b0; er = 1'b0; lv = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (load_time || load_alarm || entry_error) begin
        seen = 1'b1;
        lt   = load_time;
        la   = load_alarm;
        er   = entry_error;
        lv   = load_value;
      end else begin
        step(1'b0, 1'b0, 10'h000);
      end
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, ".entry_active"}, 32'(entry_active), 32'd0);
    chk({pfx, ".entry_mode"},   32'(entry_mode),   32'd0);
    chk({pfx, ".digit_count"},  32'(digit_count),  32'd0);
    chk({pfx, ".entry_digits"}, 32'(entry_digits), 32'd0);
    chk({pfx, ".load_time"},    32'(load_time),    32'd0);
    chk({pfx, ".load_alarm"},   32'(load_alarm),   32'd0);
    chk({pfx, ".load_value"},   32'(load_value),   32'd0);
    chk({pfx, ".entry_error"},  32'(entry_error),  32'd0);
  endtask

  initial begin
    logic        seen, lt, la, er;
    logic [15:0] lv;
    logic        any_bad;

    // Time 12:34, key in IDLE ignored, alarm 06:30, invalid 24:00
    vecs[0]  = mk(1,0,10'h000, 1,0,3'd0,16'h0000, 0,0,16'h0000,0);
    vecs[1]  = mk(1,0,10'h000, 1,0,3'd0,16'h0000, 0,0,16'h0000,0);
    vecs[2]  = mk(0,0,10'h002, 1,0,3'd1,16'h0001, 0,0,16'h0000,0);
    vecs[3]  = mk(0,0,10'h002, 1,0,3'd1,16'h0001, 0,0,16'h0000,0);
    vecs[4]  = mk(0,0,10'h000, 1,0,3'd1,16'h0001, 0,0,16'h0000,0);
    vecs[5]  = mk(0,0,10'h004, 1,0,3'd2,16'h0012, 0,0,16'h0000,0);
    vecs[6]  = mk(0,0,10'h000, 1,0,3'd2,16'h0012, 0,0,16'h0000,0);
    vecs[7]  = mk(0,0,10'h003, 1,0,3'd2,16'h0012, 0,0,16'h0000,0);
    vecs[8]  = mk(0,0,10'h000, 1,0,3'd2,16'h0012, 0,0,16'h0000,0);
    vecs[9]  = mk(0,0,10'h008, 1,0,3'd3,16'h0123, 0,0,16'h0000,0);
    vecs[10] = mk(0,0,10'h000, 1,0,3'd3,16'h0123, 0,0,16'h0000,0);
    vecs[11] = mk(0,0,10'h010, 1,0,3'd4,16'h1234, 0,0,16'h0000,0);
    vecs[12] = mk(0,0,10'h000, 0,0,3'd4,16'h1234, 1,0,16'h1234,0);
    vecs[13] = mk(0,0,10'h000, 0,0,3'd4,16'h1234, 0,0,16'h1234,0);
    vecs[14] = mk(0,0,10'h020, 0,0,3'd4,16'h1234, 0,0,16'h1234,0);
    vecs[15] = mk(0,1,10'h000, 1,1,3'd0,16'h0000, 0,0,16'h1234,0);
    vecs[16] = mk(0,0,10'h001, 1,1,3'd1,16'h0000, 0,0,16'h1234,0);
    vecs[17] = mk(0,0,10'h000, 1,1,3'd1,16'h0000, 0,0,16'h1234,0);
    vecs[18] = mk(0,0,10'h040, 1,1,3'd2,16'h0006, 0,0,16'h1234,0);
    vecs[19] = mk(0,0,10'h000, 1,1,3'd2,16'h0006, 0,0,16'h1234,0);
    vecs[20] = mk(0,0,10'h008, 1,1,3'd3,16'h0063, 0,0,16'h1234,0);
    vecs[21] = mk(0,0,10'h000, 1,1,3'd3,16'h0063, 0,0,16'h1234,0);
    vecs[22] = mk(0,0,10'h001, 1,1,3'd4,16'h0630, 0,0,16'h1234,0);
    vecs[23] = mk(0,0,10'h000, 0,1,3'd4,16'h0630, 0,1,16'h0630,0);
    vecs[24] = mk(0,0,10'h000, 0,1,3'd4,16'h0630, 0,0,16'h0630,0);
    vecs[25] = mk(1,0,10'h000, 1,0,3'd0,16'h0000, 0,0,16'h0630,0);
    vecs[26] = mk(0,0,10'h004, 1,0,3'd1,16'h0002, 0,0,16'h0630,0);
    vecs[27] = mk(0,0,10'h000, 1,0,3'd1,16'h0002, 0,0,16'h0630,0);
    vecs[28] = mk(0,0,10'h010, 1,0,3'd2,16'h0024, 0,0,16'h0630,0);
    vecs[29] = mk(0,0,10'h000, 1,0,3'd2,16'h0024, 0,0,16'h0630,0);
    vecs[30] = mk(0,0,10'h001, 1,0,3'd3,16'h0240, 0,0,16'h0630,0);
    vecs[31] = mk(0,0,10'h000, 1,0,3'd3,16'h0240, 0,0,16'h0630,0);
    vecs[32] = mk(0,0,10'h001, 1,0,3'd4,16'h2400, 0,0,16'h0630,0);
    vecs[33] = mk(0,0,10'h000, 0,0,3'd4,16'h2400, 0,0,16'h0630,1);
    vecs[34] = mk(0,0,10'h000, 0,0,3'd4,16'h2400, 0,0,16'h0630,0);

    reset          = 1'b0;
    time_button    = 1'b0;
    alarm_button   = 1'b0;
    keypad_buttons = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NUM_VECS; i++) begin
      step(vecs[i].tb, vecs[i].ab, vecs[i].keys);
      chk($sformatf("v%0d.entry_active", i), 32'(entry_active), 32'(vecs[i].act));
      chk($sformatf("v%0d.entry_mode", i),   32'(entry_mode),   32'(vecs[i].mode));
      chk($sformatf("v%0d.digit_count", i),  32'(digit_count),  32'(vecs[i].cnt));
      chk($sformatf("v%0d.entry_digits", i), 32'(entry_digits), 32'(vecs[i].dig));
      chk($sformatf("v%0d.load_time", i),    32'(load_time),    32'(vecs[i].lt));
      chk($sformatf("v%0d.load_alarm", i),   32'(load_alarm),   32'(vecs[i].la));
      chk($sformatf("v%0d.load_value", i),   32'(load_value),   32'(vecs[i].lv));
      chk($sformatf("v%0d.entry_error", i),  32'(entry_error),  32'(vecs[i].err));
    end

    // Upper boundary 23:59 loads as a time
    step(1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 10'h000);
    press(2); press(3); press(5); press(9);
    wait_event(seen, lt, la, er, lv);
    chk("s2359.seen",       32'(seen), 32'd1);
    chk("s2359.load_time",  32'(lt),   32'd1);
    chk("s2359.load_alarm", 32'(la),   32'd0);
    chk("s2359.error",      32'(er),   32'd0);
    chk("s2359.load_value", 32'(lv),   32'h2359);
    step(1'b0, 1'b0, 10'h000);
    chk("s2359.pulse_width", 32'(load_time), 32'd0);

    // Simultaneous edges in IDLE: time wins
    step(1'b1, 1'b1, 10'h000);
    chk("both.entry_mode",   32'(entry_mode),   32'd0);
    chk("both.entry_active", 32'(entry_active), 32'd1);
    step(1'b0, 1'b0, 10'h000);

    // Held key captures a single digit
    for (int i = 0; i < HOLD_CYCLES; i++) step(1'b0, 1'b0, 10'h080);
    chk("hold.digit_count",  32'(digit_count),  32'd1);
    chk("hold.entry_digits", 32'(entry_digits), 32'h0007);
    step(1'b0, 1'b0, 10'h000);
    press(1); press(2);
    chk("pre_rst.digit_count", 32'(digit_count), 32'd3);

    // Asynchronous reset mid-entry discards everything
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    any_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 10'h000);
      if (load_time || load_alarm || entry_error || entry_active) any_bad = 1'b1;
    end
    chk("post_rst.quiet", 32'(any_bad), 32'd0);

    // Alarm edge restarts a time entry; a same-cycle key is discarded
    step(1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 10'h000);
    press(4); press(5);
    chk("restart.pre_count", 32'(digit_count), 32'd2);
    step(1'b0, 1'b1, 10'h001);
    chk("restart.digit_count",  32'(digit_count),  32'd0);
    chk("restart.entry_mode",   32'(entry_mode),   32'd1);
    chk("restart.entry_active", 32'(entry_active), 32'd1);
    chk("restart.entry_digits", 32'(entry_digits), 32'h0000);
    step(1'b0, 1'b0, 10'h000);
    press(0); press(0); press(0); press(0);
    wait_event(seen, lt, la, er, lv);
    chk("restart.seen",       32'(seen), 32'd1);
    chk("restart.load_alarm", 32'(la),   32'd1);
    chk("restart.load_time",  32'(lt),   32'd0);
    chk("restart.load_value", 32'(lv),   32'h0000);
    step(1'b0, 1'b0, 10'h000);

`ifdef KEYPAD_TIMEOUT_EN
    // Inter-key timeout aborts with an error pulse
    step(1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 10'h000);
    press(1);
    chk("tmo.digit_count_before", 32'(digit_count), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 1'b0, 10'h000);
      if (entry_error) seen = 1'b1;
    end
    chk("tmo.error_seen",   32'(seen),         32'd1);
    chk("tmo.entry_active", 32'(entry_active), 32'd0);
    chk("tmo.digit_count",  32'(digit_count),  32'd0);
    chk("tmo.entry_digits", 32'(entry_digits), 32'h0000);
    chk("tmo.load_time",    32'(load_time),    32'd0);
    step(1'b0, 1'b0, 10'h000);
    chk("tmo.pulse_width",  32'(entry_error),  32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
